gate_unit_pipe: RTL and testbench

- Parametrised successor to the team's single-bit inverter. Applies one of eight bitwise logic operations to WIDTH-bit operands.
- Results are buffered in a DEPTH-entry first-word-fall-through output queue behind valid/ready handshakes.
- Serves as the reusable logic-gate stage of the simulation datapath, replacing the fixed one-bit NOT.

---
 rtl/gate_unit_pipe.sv | 109 ++++++++++
 tb/tb_gate_unit_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gate_unit_pipe.sv
// Bitwise logic-gate stage: applies one of eight gate ops to WIDTH-bit operands
// and buffers results in a DEPTH-entry first-word-fall-through queue.

package gate_unit_pipe_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_BUF  = 3'b111
  } op_e;

endpackage

module gate_unit_pipe
  import gate_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             z_zero,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    result = '0;
    case (op_e'(op))
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_BUF:  result = a;
      default: result = '0;
    endcase
  end

  // Ready/valid come from registered occupancy only: no out_ready -> in_ready path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed after a push has written it, and count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= result;
  end

  assign z      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign z_zero = out_valid && (z == '0);
  assign count  = count_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Scoreboard bench for gate_unit_pipe (WIDTH=8, DEPTH=2): directed scenarios
// followed by a randomized stream, checked against a spec-level gate model.

module tb_gate_unit_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] z;
  logic             z_zero;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  gate_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .z_zero    (z_zero),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (o)
      3'd0: return ~x;
      3'd1: return x & y;
      3'd2: return x | y;
      3'd3: return x ^ y;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // One clock cycle: check status against the model, drive inputs, record accepts.
  task automatic step(input bit r, input bit iv, input logic [2:0] o,
                      input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                      input bit ordy, input logic [WIDTH-1:0] e);
    int occ;
    @(negedge clk);
    occ = exp_q.size();
    if (armed) begin
      check("count", 32'(count), 32'(occ));
      check("in_ready", 32'(in_ready), 32'(occ != DEPTH));
      check("out_valid", 32'(out_valid), 32'(occ != 0));
      check("z_head", 32'(z), (occ != 0) ? 32'(exp_q[0]) : 32'h0);
      check("z_zero", 32'(z_zero), 32'((occ != 0) && (exp_q[0] == '0)));
    end
    rst       = r;
    in_valid  = iv;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    if (r) exp_q.delete();
    else if (iv && occ != DEPTH) exp_q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom), ordy, 8'h00);
  endtask

  // Monitor: on every cycle where a pop will occur, compare the head to the scoreboard.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (armed && !rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(z), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_z", 32'(z), 32'(e));
          check("pop_z_zero", 32'(z_zero), 32'(e == '0));
        end
      end
    end
  end

  logic [WIDTH-1:0] op_tbl [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};

  initial begin
    // Reset for two cycles, then idle.
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(1'b0);
    idle(1'b1);

    // Every opcode with a=F0, b=CC, consumer always ready.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 8'hF0, 8'hCC, 1'b1, op_tbl[i]);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: fill, attempt a third push, then release.
    step(1'b0, 1'b1, 3'd1, 8'hFF, 8'h0F, 1'b0, 8'h0F);
    step(1'b0, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Steady push+pop at occupancy 1, exercising pointer wrap.
    step(1'b0, 1'b1, 3'd3, 8'h12, 8'h34, 1'b0, 8'h26);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] o;
      logic [WIDTH-1:0] aa, bb;
      o = 3'($urandom); aa = 8'($urandom); bb = 8'($urandom);
      step(1'b0, 1'b1, o, aa, bb, 1'b1, ref_gate(o, aa, bb));
    end
    idle(1'b1);
    idle(1'b1);

    // Reset with two entries queued, then a fresh push.
    step(1'b0, 1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 3'd0, 8'h5A, 8'h00, 1'b0, 8'hA5);
    step(1'b1, 1'b1, 3'd1, 8'hFF, 8'hFF, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 3'd3, 8'hAA, 8'h55, 1'b0, 8'hFF);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random stream.
    for (int i = 0; i < 1000; i++) begin
      logic [2:0] o;
      logic [WIDTH-1:0] aa, bb;
      bit iv, ordy;
      o = 3'($urandom); aa = 8'($urandom); bb = 8'($urandom);
      if (($urandom % 8) == 0) bb = aa;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      step(1'b0, iv, o, aa, bb, ordy, ref_gate(o, aa, bb));
    end

    // Drain with a bounded cycle budget; the final step checks the empty state.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
